mc_control_unit: RTL and testbench

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

---
 rtl/ctrl_pkg.sv | 47 ++++
 rtl/alu_ctrl_dec.sv | 51 +++++
 rtl/mc_control_unit.sv | 151 +++++++++++++++
 tb/tb_mc_control_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module  : ctrl_pkg
// Brief   : Shared FSM states, opcodes and ALU encodings for mc_control_unit.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [6:0] c_opc_r      = 7'b0110011;
  localparam logic [6:0] c_opc_i      = 7'b0010011;
  localparam logic [6:0] c_opc_load   = 7'b0000011;
  localparam logic [6:0] c_opc_store  = 7'b0100011;
  localparam logic [6:0] c_opc_branch = 7'b1100011;
  localparam logic [6:0] c_opc_jal    = 7'b1101111;

  // funct7 value that selects the multiply/divide extension space
  localparam logic [6:0] c_f7_ext     = 7'b0000001;

  localparam logic [1:0] c_aluop_mem  = 2'b00;
  localparam logic [1:0] c_aluop_br   = 2'b01;
  localparam logic [1:0] c_aluop_r    = 2'b10;
  localparam logic [1:0] c_aluop_i    = 2'b11;

  localparam logic [3:0] c_alu_add    = 4'b0000;
  localparam logic [3:0] c_alu_sub    = 4'b0001;
  localparam logic [3:0] c_alu_and    = 4'b0010;
  localparam logic [3:0] c_alu_or     = 4'b0011;
  localparam logic [3:0] c_alu_xor    = 4'b0100;
  localparam logic [3:0] c_alu_sll    = 4'b0101;
  localparam logic [3:0] c_alu_srl    = 4'b0110;
  localparam logic [3:0] c_alu_sra    = 4'b0111;
  localparam logic [3:0] c_alu_slt    = 4'b1000;
  localparam logic [3:0] c_alu_sltu   = 4'b1001;
  localparam logic [3:0] c_alu_mul    = 4'b1010;

endpackage

`default_nettype wire

// File: rtl/alu_ctrl_dec.sv
//------------------------------------------------------------------------------
// Module  : alu_ctrl_dec
// Brief   : Combinational ALUOp/funct3/funct7 to ALU function decode.
//           MUL decode is present only when MUL_EXT_EN is defined.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_ctrl_dec
  import ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_ctrl
);

`ifndef MUL_EXT_EN
  logic w_unused;
  assign w_unused = ^{funct7[6], funct7[4:0]};
`endif

  always_comb begin
    alu_ctrl = c_alu_add;
    case (aluop)
      c_aluop_mem: alu_ctrl = c_alu_add;
      c_aluop_br:  alu_ctrl = c_alu_sub;
      default: begin
        case (funct3)
          3'b000: begin
            // SUB exists only for register-register operations
            alu_ctrl = (aluop == c_aluop_r && funct7[5]) ? c_alu_sub : c_alu_add;
`ifdef MUL_EXT_EN
            if (aluop == c_aluop_r && funct7 == c_f7_ext) alu_ctrl = c_alu_mul;
`endif
          end
          3'b001:  alu_ctrl = c_alu_sll;
          3'b010:  alu_ctrl = c_alu_slt;
          3'b011:  alu_ctrl = c_alu_sltu;
          3'b100:  alu_ctrl = c_alu_xor;
          3'b101:  alu_ctrl = funct7[5] ? c_alu_sra : c_alu_srl;
          3'b110:  alu_ctrl = c_alu_or;
          default: alu_ctrl = c_alu_and;
        endcase
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_control_unit.sv
//------------------------------------------------------------------------------
// Module  : mc_control_unit
// Brief   : Multi-cycle CPU control FSM (FETCH/DECODE/EXEC/MEM/WB).
//           Optional feature macro: MUL_EXT_EN (multi-cycle MUL support).
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mc_control_unit
  import ctrl_pkg::*;
#(
  parameter int OPLEN = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPLEN-1:0] op,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             mem_ready,
  input  logic             alu_done,
  output logic             mem_req,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             memtoreg,
  output logic [1:0]       ALUOp,
  output logic             ALUSrc,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             branch,
  output logic             pc_signal,
  output logic [3:0]       ALUOp_control,
  output logic             illegal,
  output logic             instr_done
);

  state_t     r_state;
  state_t     w_next;
  logic       r_mem_req, r_memread, r_memwrite, r_regwrite, r_memtoreg;
  logic       r_alusrc, r_branch, r_pc_signal, r_jal_pcwrite, r_done;
  logic       r_in_fetch, r_in_decode, r_store_mem;
  logic [1:0] r_aluop;
  logic [1:0] w_aluop_class;
  logic       w_is_r, w_is_i, w_is_ld, w_is_st, w_is_br, w_is_jal;
  logic       w_ext, w_is_mul, w_alu_wait, w_legal, w_hs;

  assign w_is_r   = (op == OPLEN'(c_opc_r));
  assign w_is_i   = (op == OPLEN'(c_opc_i));
  assign w_is_ld  = (op == OPLEN'(c_opc_load));
  assign w_is_st  = (op == OPLEN'(c_opc_store));
  assign w_is_br  = (op == OPLEN'(c_opc_branch));
  assign w_is_jal = (op == OPLEN'(c_opc_jal));
  assign w_ext    = (funct7 == c_f7_ext);

`ifdef MUL_EXT_EN
  assign w_is_mul   = w_is_r && w_ext && (funct3 == 3'b000);
  assign w_alu_wait = w_is_mul && !alu_done;
`else
  logic w_unused;
  assign w_unused   = alu_done;
  assign w_is_mul   = 1'b0;
  assign w_alu_wait = 1'b0;
`endif

  assign w_legal = (w_is_r && (!w_ext || w_is_mul)) || w_is_i || w_is_ld ||
                   w_is_st || w_is_br || w_is_jal;

  assign w_aluop_class = w_is_r  ? c_aluop_r  :
                         w_is_i  ? c_aluop_i  :
                         w_is_br ? c_aluop_br : c_aluop_mem;

  // Handshake completions are ignored while reset is asserted
  assign w_hs = mem_ready && !rst;

  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH:   if (mem_ready) w_next = DECODE;
      DECODE:  w_next = w_legal ? EXEC : FETCH;
      EXEC: begin
        if (w_is_ld || w_is_st) w_next = MEM;
        else if (w_is_br)       w_next = FETCH;
        else if (!w_alu_wait)   w_next = WB;
      end
      MEM:     if (mem_ready) w_next = w_is_ld ? WB : FETCH;
      WB:      w_next = FETCH;
      default: w_next = FETCH;
    endcase
  end

  // Outputs are registered from the destination state; op is stable from DECODE on
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= FETCH;
      r_mem_req     <= 1'b1;
      r_memread     <= 1'b1;
      r_memwrite    <= 1'b0;
      r_store_mem   <= 1'b0;
      r_in_fetch    <= 1'b1;
      r_in_decode   <= 1'b0;
      r_alusrc      <= 1'b0;
      r_aluop       <= c_aluop_mem;
      r_branch      <= 1'b0;
      r_pc_signal   <= 1'b0;
      r_jal_pcwrite <= 1'b0;
      r_done        <= 1'b0;
      r_regwrite    <= 1'b0;
      r_memtoreg    <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_mem_req     <= (w_next == FETCH) || (w_next == MEM);
      r_memread     <= (w_next == FETCH) || (w_next == MEM && w_is_ld);
      r_memwrite    <= (w_next == MEM) && w_is_st;
      r_store_mem   <= (w_next == MEM) && w_is_st;
      r_in_fetch    <= (w_next == FETCH);
      r_in_decode   <= (w_next == DECODE);
      r_alusrc      <= (w_next == EXEC) && (w_is_i || w_is_ld || w_is_st);
      r_aluop       <= (w_next == EXEC || w_next == MEM) ? w_aluop_class : c_aluop_mem;
      r_branch      <= (w_next == EXEC) && w_is_br;
      r_pc_signal   <= (w_next == EXEC) && w_is_jal;
      r_jal_pcwrite <= (w_next == EXEC) && w_is_jal;
      r_done        <= ((w_next == EXEC) && w_is_br) || (w_next == WB);
      r_regwrite    <= (w_next == WB);
      r_memtoreg    <= (w_next == WB) && w_is_ld;
    end
  end

  assign mem_req    = r_mem_req;
  assign MemRead    = r_memread;
  assign MemWrite   = r_memwrite;
  assign ALUSrc     = r_alusrc;
  assign ALUOp      = r_aluop;
  assign branch     = r_branch;
  assign pc_signal  = r_pc_signal;
  assign RegWrite   = r_regwrite;
  assign memtoreg   = r_memtoreg;
  assign IRWrite    = r_in_fetch && w_hs;
  assign PCWrite    = (r_in_fetch && w_hs) || r_jal_pcwrite;
  assign instr_done = r_done || (r_store_mem && w_hs);
  assign illegal    = r_in_decode && !w_legal;

  alu_ctrl_dec u_alu_ctrl_dec (
    .aluop    (r_aluop),
    .funct3   (funct3),
    .funct7   (funct7),
    .alu_ctrl (ALUOp_control)
  );

endmodule

`default_nettype wire

// File: tb/tb_mc_control_unit.sv
//------------------------------------------------------------------------------
// Module  : tb_mc_control_unit
// Brief   : Randomized self-checking bench with a per-instruction trace model.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mc_control_unit;

  logic       clk = 1'b0;
  logic       rst, mem_ready, alu_done;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       mem_req, IRWrite, PCWrite, memtoreg, ALUSrc, RegWrite;
  logic       MemRead, MemWrite, branch, pc_signal, illegal, instr_done;
  logic [1:0] ALUOp;
  logic [3:0] ALUOp_control;

  typedef struct packed {
    logic       mem_req;
    logic       irwrite;
    logic       pcwrite;
    logic       memtoreg;
    logic [1:0] aluop;
    logic       alusrc;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       pc_signal;
    logic [3:0] aluctl;
    logic       illegal;
    logic       instr_done;
  } obs_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc_no   = 0;
  int   instr_cyc;
  int   lat_seen;
  obs_t exec_seen;

  mc_control_unit #(.OPLEN(7)) dut (
    .clk           (clk),
    .rst           (rst),
    .op            (op),
    .funct3        (funct3),
    .funct7        (funct7),
    .mem_ready     (mem_ready),
    .alu_done      (alu_done),
    .mem_req       (mem_req),
    .IRWrite       (IRWrite),
    .PCWrite       (PCWrite),
    .memtoreg      (memtoreg),
    .ALUOp         (ALUOp),
    .ALUSrc        (ALUSrc),
    .RegWrite      (RegWrite),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .branch        (branch),
    .pc_signal     (pc_signal),
    .ALUOp_control (ALUOp_control),
    .illegal       (illegal),
    .instr_done    (instr_done)
  );

  always #5 clk = ~clk;

  function automatic logic noise();
    return 1'($urandom);
  endfunction

  function automatic bit op_known(input logic [6:0] o);
    return o == 7'b0110011 || o == 7'b0010011 || o == 7'b0000011 ||
           o == 7'b0100011 || o == 7'b1100011 || o == 7'b1101111;
  endfunction

  // ALU function table, straight from the instruction-set encoding
  function automatic logic [3:0] ref_aluctl(input logic [1:0] aluop, input logic [2:0] f3,
                                            input logic [6:0] f7);
    if (aluop == 2'b00) return 4'b0000;
    if (aluop == 2'b01) return 4'b0001;
`ifdef MUL_EXT_EN
    if (aluop == 2'b10 && f7 == 7'b0000001 && f3 == 3'b000) return 4'b1010;
`endif
    case (f3)
      3'd0:    return (aluop == 2'b10 && f7[5]) ? 4'b0001 : 4'b0000;
      3'd1:    return 4'b0101;
      3'd2:    return 4'b1000;
      3'd3:    return 4'b1001;
      3'd4:    return 4'b0100;
      3'd5:    return f7[5] ? 4'b0111 : 4'b0110;
      3'd6:    return 4'b0011;
      default: return 4'b0010;
    endcase
  endfunction

  // Called at a falling edge: apply inputs, compare outputs, advance one cycle
  task automatic cyc(input logic mr, input logic ad, input logic r, input obs_t exp,
                     input string tag);
    obs_t act;
    mem_ready = mr;
    alu_done  = ad;
    rst       = r;
    #1;
    act.mem_req    = mem_req;
    act.irwrite    = IRWrite;
    act.pcwrite    = PCWrite;
    act.memtoreg   = memtoreg;
    act.aluop      = ALUOp;
    act.alusrc     = ALUSrc;
    act.regwrite   = RegWrite;
    act.memread    = MemRead;
    act.memwrite   = MemWrite;
    act.branch     = branch;
    act.pc_signal  = pc_signal;
    act.aluctl     = ALUOp_control;
    act.illegal    = illegal;
    act.instr_done = instr_done;
    instr_cyc++;
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc_no, act, exp);
    if (lat_seen == 0 && (act.instr_done === 1'b1 || act.illegal === 1'b1)) lat_seen = instr_cyc;
    if (tag == "exec") exec_seen = act;
    cyc_no++;
    @(negedge clk);
  endtask

  task automatic check_lit(input string tag, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, want);
  endtask

  // Builds the expected cycle-by-cycle trace of one instruction and checks it
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                           input int fw, input int mw, input int aw, input bit rst_mem);
    obs_t e, z;
    bit   is_r, is_i, is_ld, is_st, is_br, is_jal, ext, mul, legal;
    z = '0;
    op = o; funct3 = f3; funct7 = f7;
    lat_seen = 0; instr_cyc = 0;
    is_r = (o == 7'b0110011); is_i = (o == 7'b0010011); is_ld = (o == 7'b0000011);
    is_st = (o == 7'b0100011); is_br = (o == 7'b1100011); is_jal = (o == 7'b1101111);
    ext = (f7 == 7'b0000001);
    mul = 1'b0;
`ifdef MUL_EXT_EN
    mul = is_r && ext && f3 == 3'b000;
`endif
    legal = (is_r && (!ext || mul)) || is_i || is_ld || is_st || is_br || is_jal;

    e = z; e.mem_req = 1'b1; e.memread = 1'b1;
    for (int i = 0; i < fw; i++) cyc(1'b0, noise(), 1'b0, e, "fetch");
    e.irwrite = 1'b1; e.pcwrite = 1'b1;
    cyc(1'b1, noise(), 1'b0, e, "fetch");

    e = z; e.illegal = !legal;
    cyc(noise(), noise(), 1'b0, e, "decode");
    if (!legal) return;

    e = z;
    e.aluop     = is_r ? 2'b10 : is_i ? 2'b11 : is_br ? 2'b01 : 2'b00;
    e.alusrc    = is_i || is_ld || is_st;
    e.branch    = is_br;
    e.instr_done = is_br;
    e.pc_signal = is_jal;
    e.pcwrite   = is_jal;
    e.aluctl    = ref_aluctl(e.aluop, f3, f7);
    if (mul) begin
      for (int i = 0; i < aw; i++) cyc(noise(), 1'b0, 1'b0, e, "exec");
      cyc(noise(), 1'b1, 1'b0, e, "exec");
    end else begin
      cyc(noise(), noise(), 1'b0, e, "exec");
    end
    if (is_br) return;

    if (is_ld || is_st) begin
      e = z; e.mem_req = 1'b1; e.memread = is_ld; e.memwrite = is_st;
      for (int i = 0; i < mw; i++) cyc(1'b0, noise(), 1'b0, e, "mem");
      if (rst_mem) begin
        cyc(noise(), noise(), 1'b1, e, "mem_rst");
        return;
      end
      e.instr_done = is_st;
      cyc(1'b1, noise(), 1'b0, e, "mem");
      if (is_st) return;
    end

    e = z; e.regwrite = 1'b1; e.memtoreg = is_ld; e.instr_done = 1'b1;
    cyc(noise(), noise(), 1'b0, e, "wb");
  endtask

  initial begin
    obs_t       e;
    logic [6:0] o, f7;
    int         kind;
    rst = 1'b1; mem_ready = 1'b0; alu_done = 1'b0;
    op = '0; funct3 = '0; funct7 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    e = '0; e.mem_req = 1'b1; e.memread = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, e, "reset");

    run_instr(7'b0110011, 3'b000, 7'b0000000, 0, 0, 0, 1'b0);
    check_lit("add_latency", lat_seen, 4);
    check_lit("add_aluctl", int'(exec_seen.aluctl), 0);

    run_instr(7'b0000011, 3'b010, 7'b0000000, 0, 3, 0, 1'b0);
    check_lit("load_wait_latency", lat_seen, 8);
    run_instr(7'b0000011, 3'b010, 7'b0000000, 0, 0, 0, 1'b0);
    check_lit("load_latency", lat_seen, 5);

    run_instr(7'b1111111, 3'b000, 7'b0000000, 0, 0, 0, 1'b0);
    check_lit("illegal_latency", lat_seen, 2);

    run_instr(7'b0100011, 3'b010, 7'b0000000, 0, 1, 0, 1'b1);
    check_lit("store_rst_no_done", lat_seen, 0);
    run_instr(7'b0100011, 3'b010, 7'b0000000, 0, 0, 0, 1'b0);
    check_lit("store_latency", lat_seen, 4);

    run_instr(7'b0010011, 3'b101, 7'b0100000, 0, 0, 0, 1'b0);
    check_lit("sra_latency", lat_seen, 4);
    check_lit("sra_aluop", int'(exec_seen.aluop), 3);
    check_lit("sra_aluctl", int'(exec_seen.aluctl), 7);
    check_lit("sra_alusrc", int'(exec_seen.alusrc), 1);

    run_instr(7'b1100011, 3'b000, 7'b0000000, 0, 0, 0, 1'b0);
    check_lit("branch_latency", lat_seen, 3);
    run_instr(7'b1101111, 3'b000, 7'b0000000, 0, 0, 0, 1'b0);
    check_lit("jal_latency", lat_seen, 4);

    run_instr(7'b0110011, 3'b000, 7'b0000001, 0, 0, 2, 1'b0);
`ifdef MUL_EXT_EN
    check_lit("mul_latency", lat_seen, 6);
    check_lit("mul_aluctl", int'(exec_seen.aluctl), 10);
`else
    check_lit("mul_illegal_latency", lat_seen, 2);
`endif

    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 7);
      f7 = 7'($urandom);
      case (kind)
        0: begin
          o = 7'b0110011;
          if ($urandom_range(0, 2) != 0) f7 = $urandom_range(0, 1) != 0 ? 7'b0100000 : 7'b0000000;
        end
        1: o = 7'b0010011;
        2: o = 7'b0000011;
        3: o = 7'b0100011;
        4: o = 7'b1100011;
        5: o = 7'b1101111;
        6: begin
          o = 7'($urandom);
          if (op_known(o)) o = 7'b1111111;
        end
        default: begin
          o = 7'b0110011;
          f7 = 7'b0000001;
        end
      endcase
      run_instr(o, 3'($urandom), f7, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), (kind == 2 || kind == 3) && $urandom_range(0, 5) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
